// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column scan with press/release debounce and a valid/ready key output.
// Optional feature: define KEYPAD_REPEAT_EN to emit auto-repeat codes while a key stays held.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 48000,
    parameter int unsigned DEBOUNCE_FRAMES = 4,
    parameter int unsigned REPEAT_FRAMES   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overflow,
    input  logic       ovf_clr
);
    localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int unsigned RPT_W  = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_FRAMES);
    localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(REPEAT_FRAMES - 1);
`ifdef KEYPAD_REPEAT_EN
    localparam bit RPT_ON = 1'b1;
`else
    localparam bit RPT_ON = 1'b0;
`endif

    typedef enum logic [1:0] {SCAN_IDLE, PRESS_DB, PRESSED, REL_DB} state_t;

    logic [3:0]        row_meta, row_s;
    logic [SLOT_W-1:0] slot_cnt;
    logic [1:0]        col_idx;
    logic [15:0]       frame_acc, frame_c;
    logic              slot_end_c, frame_end_c;
    logic [4:0]        n_set_c;
    logic [3:0]        code_c;
    logic              none_c, single_c;

    state_t            state, state_nx;
    logic [DB_W-1:0]   db_cnt, db_cnt_nx;
    logic [3:0]        cand, cand_nx;
    logic [RPT_W-1:0]  rpt_cnt, rpt_cnt_nx;
    logic              accept_c;

    // Two-flop synchronizer for the asynchronous rows
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'hF;
            row_s    <= 4'hF;
        end else begin
            row_meta <= row_n;
            row_s    <= row_meta;
        end
    end

    assign slot_end_c  = (slot_cnt == SLOT_LAST);
    assign frame_end_c = slot_end_c && (col_idx == 2'd3);

    // Frame bitmap including the current column's sample; bit index = {row, col}
    always_comb begin
        frame_c = frame_acc;
        for (int r = 0; r < 4; r++) begin
            if (!row_s[r]) frame_c[{2'(r), col_idx}] = 1'b1;
        end
    end

    always_comb begin
        n_set_c = '0;
        code_c  = '0;
        for (int i = 0; i < 16; i++) begin
            if (frame_c[i]) begin
                n_set_c = n_set_c + 5'd1;
                code_c  = 4'(i);
            end
        end
    end

    assign none_c   = (n_set_c == 5'd0);
    assign single_c = (n_set_c == 5'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt  <= '0;
            col_idx   <= '0;
            col_n     <= 4'b1110;
            frame_acc <= '0;
        end else if (slot_end_c) begin
            slot_cnt  <= '0;
            col_idx   <= col_idx + 2'd1;
            col_n     <= {col_n[2:0], col_n[3]};
            frame_acc <= frame_end_c ? 16'h0000 : frame_c;
        end else begin
            slot_cnt  <= slot_cnt + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SCAN_IDLE;
            db_cnt  <= '0;
            cand    <= '0;
            rpt_cnt <= '0;
        end else begin
            state   <= state_nx;
            db_cnt  <= db_cnt_nx;
            cand    <= cand_nx;
            rpt_cnt <= rpt_cnt_nx;
        end
    end

    // Debounce FSM, advancing only on the frame evaluation cycle
    always_comb begin
        state_nx   = state;
        db_cnt_nx  = db_cnt;
        cand_nx    = cand;
        rpt_cnt_nx = rpt_cnt;
        accept_c   = 1'b0;
        if (frame_end_c) begin
            case (state)
                SCAN_IDLE: begin
                    if (single_c) begin
                        cand_nx = code_c;
                        if (DEBOUNCE_FRAMES == 1) begin
                            accept_c   = 1'b1;
                            state_nx   = PRESSED;
                            db_cnt_nx  = '0;
                            rpt_cnt_nx = '0;
                        end else begin
                            db_cnt_nx = DB_W'(1);
                            state_nx  = PRESS_DB;
                        end
                    end
                end
                PRESS_DB: begin
                    if (single_c && (code_c == cand)) begin
                        if (db_cnt + DB_W'(1) == DB_LAST) begin
                            accept_c   = 1'b1;
                            state_nx   = PRESSED;
                            db_cnt_nx  = '0;
                            rpt_cnt_nx = '0;
                        end else begin
                            db_cnt_nx = db_cnt + DB_W'(1);
                        end
                    end else if (single_c) begin
                        cand_nx   = code_c;
                        db_cnt_nx = DB_W'(1);
                    end else begin
                        state_nx  = SCAN_IDLE;
                        db_cnt_nx = '0;
                    end
                end
                PRESSED: begin
                    if (none_c) begin
                        rpt_cnt_nx = '0;
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_nx  = SCAN_IDLE;
                            db_cnt_nx = '0;
                        end else begin
                            state_nx  = REL_DB;
                            db_cnt_nx = DB_W'(1);
                        end
                    end else begin
                        db_cnt_nx = '0;
                        if (RPT_ON && single_c && (code_c == cand)) begin
                            if (rpt_cnt == RPT_LAST) begin
                                accept_c   = 1'b1;
                                rpt_cnt_nx = '0;
                            end else begin
                                rpt_cnt_nx = rpt_cnt + RPT_W'(1);
                            end
                        end
                    end
                end
                REL_DB: begin
                    rpt_cnt_nx = '0;
                    if (none_c) begin
                        if (db_cnt + DB_W'(1) == DB_LAST) begin
                            state_nx  = SCAN_IDLE;
                            db_cnt_nx = '0;
                        end else begin
                            db_cnt_nx = db_cnt + DB_W'(1);
                        end
                    end else begin
                        state_nx  = PRESSED;
                        db_cnt_nx = '0;
                    end
                end
                default: state_nx = SCAN_IDLE;
            endcase
        end
    end

    // Output handshake: a press accepted while a code is still pending is dropped and flagged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            key_held <= (state_nx == PRESSED) || (state_nx == REL_DB);
            if (accept_c && (!key_valid || key_ready)) begin
                key_code  <= code_c;
                key_valid <= 1'b1;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
            if (ovf_clr) begin
                overflow <= 1'b0;
            end else if (accept_c && key_valid && !key_ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model driving keypad_scanner, frame-history reference model and directed tests.
// Build with KEYPAD_REPEAT_EN defined to exercise auto-repeat.
module tb_keypad_scanner;
    localparam int DB   = 3;
    localparam int RPT  = 5;
    localparam int FRM  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_n, col_n, key_code;
    logic       key_valid, key_ready, key_held, overflow, ovf_clr;
    logic [15:0] keys;

    int checks = 0;
    int failures = 0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(DB), .REPEAT_FRAMES(RPT)) dut (
        .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n), .key_code(key_code),
        .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Switch matrix: a pressed key at (r,c) pulls row r low while column c is driven low
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_n[r] = ~(|(keys[r*4 +: 4] & ~col_n));
        end
    end

    // Reference model state
    int          n;
    int          hist[$];
    bit          m_held, m_acc, m_ovf_set;
    int          m_cand, m_rep, m_cls;
    logic [3:0]  m_code, m_col;
    bit          m_valid, m_ovf;
    int          taken;
    logic [3:0]  taken_code;

    function automatic int classify(logic [15:0] k);
        int cnt = 0;
        int c = 0;
        for (int i = 0; i < 16; i++) begin
            if (k[i]) begin
                cnt++;
                c = i;
            end
        end
        return (cnt == 0) ? -1 : ((cnt == 1) ? c : -2);
    endfunction

    // True when the most recent DB frames all classified as code
    function automatic bit run_of(int code);
        if (hist.size() < DB) return 1'b0;
        for (int i = hist.size() - DB; i < hist.size(); i++) begin
            if (hist[i] != code) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: frames are evaluated every 16 edges after reset release from the key set held that frame
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            n = 0; hist.delete(); m_held = 0; m_cand = 0; m_rep = 0;
            m_code = 4'h0; m_valid = 0; m_ovf = 0; m_col = 4'b1110;
        end else begin
            m_acc = 0;
            m_ovf_set = 0;
            n = n + 1;
            if (n % FRM == 0) begin
                m_cls = classify(keys);
                hist.push_back(m_cls);
                if (!m_held) begin
                    if (m_cls >= 0 && run_of(m_cls)) begin
                        m_acc = 1; m_held = 1; m_cand = m_cls; m_rep = 0;
                    end
                end else if (run_of(-1)) begin
                    m_held = 0; m_rep = 0;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (m_cls == -1 || hist[hist.size()-2] == -1) begin
                    m_rep = 0;
                end else if (m_cls == m_cand) begin
                    m_rep++;
                    if (m_rep == RPT) begin
                        m_acc = 1; m_rep = 0;
                    end
                end
`endif
            end
            if (m_acc) begin
                if (!m_valid || key_ready) begin
                    m_valid = 1; m_code = 4'(m_cls);
                end else begin
                    m_ovf_set = 1;
                end
            end else if (m_valid && key_ready) begin
                m_valid = 0;
            end
            if (ovf_clr) m_ovf = 0;
            else if (m_ovf_set) m_ovf = 1;
            m_col = ~(4'b0001 << ((n / 4) % 4));
        end
    end

    // Per-cycle comparison against the model, plus a count of consumed codes
    initial forever begin
        @(negedge clk);
        check("col_n", 32'(col_n), 32'(m_col));
        check("key_valid", 32'(key_valid), 32'(m_valid));
        check("key_code", 32'(key_code), 32'(m_code));
        check("key_held", 32'(key_held), 32'(m_held));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (key_valid === 1'b1 && key_ready === 1'b1) begin
            taken++;
            taken_code = key_code;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_frames(int k);
        for (int f = 0; f < k; f++) begin
            @(posedge clk); #1;
            while (n % FRM != 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    logic [3:0] col_tab [4];
    int t0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        col_tab[0] = 4'b1101; col_tab[1] = 4'b1011; col_tab[2] = 4'b0111; col_tab[3] = 4'b1110;
        keys = 16'h0000; key_ready = 1'b1; ovf_clr = 1'b0; taken = 0; taken_code = 4'h0;
        rst = 1'b0;
        #1 rst = 1'b1;
        do_reset();

        // 1: idle column walk
        check("reset_col", 32'(col_n), 32'h0000000E);
        check("reset_valid", 32'(key_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            repeat (4) @(posedge clk);
            #1 check("col_walk", 32'(col_n), 32'(col_tab[i]));
        end
        wait_frames(2);
        check("idle_valid", 32'(key_valid), 32'h0);

        // 2: clean press of row2/col1, held 5 frames
        t0 = taken;
        keys = 16'h0200;
        wait_frames(3);
        check("press9_valid", 32'(key_valid), 32'h1);
        check("press9_code", 32'(key_code), 32'h9);
        check("model_code9", 32'(m_code), 32'h9);
        wait_frames(2);
        check("press9_held", 32'(key_held), 32'h1);
        keys = 16'h0000;
        wait_frames(2);
        check("rel_held_2", 32'(key_held), 32'h1);
        wait_frames(1);
        check("rel_held_3", 32'(key_held), 32'h0);
        check("press9_count", 32'(taken - t0), 32'h1);
        check("press9_taken", 32'(taken_code), 32'h9);

        // 3: bouncing press, then stable
        t0 = taken;
        for (int i = 0; i < 3; i++) begin
            keys = 16'h0040; wait_frames(1);
            keys = 16'h0000; wait_frames(1);
        end
        check("bounce_none", 32'(taken - t0), 32'h0);
        keys = 16'h0040;
        wait_frames(3);
        check("bounce_code", 32'(key_code), 32'h6);
        wait_frames(1);
        keys = 16'h0000;
        wait_frames(3);
        check("bounce_count", 32'(taken - t0), 32'h1);

        // 4: two keys together
        t0 = taken;
        keys = 16'h0021;
        wait_frames(5);
        check("multi_held", 32'(key_held), 32'h0);
        check("multi_count", 32'(taken - t0), 32'h0);
        keys = 16'h0000;
        wait_frames(1);

        // 5: overflow when the consumer stalls
        key_ready = 1'b0;
        keys = 16'h0008;
        wait_frames(3);
        check("ovf_first", 32'(key_code), 32'h3);
        keys = 16'h0000;
        wait_frames(3);
        keys = 16'h1000;
        wait_frames(3);
        check("ovf_code", 32'(key_code), 32'h3);
        check("ovf_valid", 32'(key_valid), 32'h1);
        check("ovf_set", 32'(overflow), 32'h1);
        check("model_ovf", 32'(m_ovf), 32'h1);
        ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'h0);
        key_ready = 1'b1;
        @(posedge clk); #1;
        check("ovf_drain", 32'(key_valid), 32'h0);
        wait_frames(1);
        keys = 16'h0000;
        wait_frames(3);

        // 6: reset in the middle of a press debounce
        key_ready = 1'b0;
        keys = 16'h0080;
        wait_frames(3);
        check("pre_rst_code", 32'(key_code), 32'h7);
        keys = 16'h0000;
        wait_frames(3);
        keys = 16'h0400;
        wait_frames(1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_col", 32'(col_n), 32'h0000000E);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_held", 32'(key_held), 32'h0);
        key_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_frames(2);
        check("rst_db_valid", 32'(key_valid), 32'h0);
        check("rst_db_held", 32'(key_held), 32'h0);
        wait_frames(1);
        check("rst_acc_valid", 32'(key_valid), 32'h1);
        check("rst_acc_code", 32'(key_code), 32'hA);
        wait_frames(1);
        keys = 16'h0000;
        wait_frames(3);

        // Long hold of 0x7: auto-repeat when enabled, otherwise a single code
        t0 = taken;
        keys = 16'h0080;
        wait_frames(20);
        keys = 16'h0000;
        wait_frames(3);
`ifdef KEYPAD_REPEAT_EN
        check("hold_count", 32'(taken - t0), 32'h4);
`else
        check("hold_count", 32'(taken - t0), 32'h1);
`endif
        check("hold_code", 32'(taken_code), 32'h7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
